// File: rtl/sar_adc_pkg.sv
// -----------------------------------------------------------------------------
// sar_adc_pkg
// Shared types and elaboration-time helpers for the SAR ADC controller.
//   sar_state_e : controller state (IDLE, SAMPLE, CONVERT)
//   bit_period  : cycles spent on one bit decision (DAC settle + 2-flop sync)
//   cnt_width   : width of the reloadable phase counter
// -----------------------------------------------------------------------------
package sar_adc_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SAMPLE  = 2'd1,
        CONVERT = 2'd2
    } sar_state_e;

    // Each bit needs the DAC to settle plus two cycles for the comparator
    // result to cross the synchroniser before it can be trusted.
    function automatic int bit_period(input int settle_cycles);
        return settle_cycles + 2;
    endfunction

    // The counter only ever holds (phase length - 1), so $clog2 of the
    // longest phase is enough; keep at least one bit.
    function automatic int cnt_width(input int sample_cycles, input int period);
        int m;
        m = (sample_cycles > period) ? sample_cycles : period;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/sar_adc_ctrl_if.sv
// -----------------------------------------------------------------------------
// sar_adc_ctrl_if
// Core-side register interface of the SAR ADC controller.
//   start  : request a conversion (core -> ctrl)
//   abort  : cancel an in-progress conversion (core -> ctrl)
//   busy   : conversion in progress (ctrl -> core)
//   done   : one-cycle pulse, result valid (ctrl -> core)
//   result : last completed conversion (ctrl -> core)
// -----------------------------------------------------------------------------
interface sar_adc_ctrl_if #(
    parameter int BITS = 8
);
    logic            start;
    logic            abort;
    logic            busy;
    logic            done;
    logic [BITS-1:0] result;

    modport master (
        output start,
        output abort,
        input  busy,
        input  done,
        input  result
    );

    modport slave (
        input  start,
        input  abort,
        output busy,
        output done,
        output result
    );
endinterface

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Two-flop synchroniser for asynchronous pad-side inputs.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset, both flops clear to 0
//   i_d   : asynchronous input
//   o_q   : synchronised output (second flop)
// -----------------------------------------------------------------------------
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);
    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;
endmodule

// File: rtl/sar_adc_ctrl.sv
// -----------------------------------------------------------------------------
// sar_adc_ctrl
// Successive-approximation controller behind the 5 V analog pad: sequences the
// track/hold switch, drives the DAC trial code and resolves one bit per period.
//   clk       : core clock
//   rst_n     : asynchronous active-low reset
//   comp_in   : asynchronous comparator output (1 = input >= DAC)
//   sample_en : closes the pad-to-hold-cap track switch
//   dac_code  : trial code to the DAC
//   bus       : core-side start/abort/busy/done/result (slave modport)
// -----------------------------------------------------------------------------
module sar_adc_ctrl
    import sar_adc_pkg::*;
#(
    parameter int BITS          = 8,
    parameter int SAMPLE_CYCLES = 4,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            comp_in,
    output logic            sample_en,
    output logic [BITS-1:0] dac_code,
    sar_adc_ctrl_if.slave   bus
);
    localparam int T  = bit_period(SETTLE_CYCLES);
    localparam int CW = cnt_width(SAMPLE_CYCLES, T);
    localparam int IW = $clog2(BITS);

    localparam logic [CW-1:0]   SAMPLE_LOAD = CW'(SAMPLE_CYCLES - 1);
    localparam logic [CW-1:0]   BIT_LOAD    = CW'(T - 1);
    localparam logic [IW-1:0]   MSB_IDX     = IW'(BITS - 1);
    localparam logic [BITS-1:0] MSB_CODE    = {1'b1, {(BITS-1){1'b0}}};

    sar_state_e      r_state;
    logic [CW-1:0]   r_cnt;
    logic [IW-1:0]   r_bit_idx;
    logic            r_sample_en;
    logic [BITS-1:0] r_dac_code;
    logic            r_busy;
    logic            r_done;
    logic [BITS-1:0] r_result;

    logic            w_comp_s;
    logic [BITS-1:0] w_keep_code;
    logic [BITS-1:0] w_next_trial;

    sync_2ff u_comp_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (comp_in),
        .o_q   (w_comp_s)
    );

    // Decision for the bit under test, and the trial code for the next bit.
    always_comb begin
        w_keep_code = r_dac_code;
        if (!w_comp_s) begin
            w_keep_code[r_bit_idx] = 1'b0;
        end
        w_next_trial = w_keep_code;
        if (r_bit_idx != '0) begin
            w_next_trial[r_bit_idx - IW'(1)] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_bit_idx   <= '0;
            r_sample_en <= 1'b0;
            r_dac_code  <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_result    <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    // start beats a simultaneous abort: abort is only looked at
                    // once a conversion is running.
                    if (bus.start) begin
                        r_state     <= SAMPLE;
                        r_cnt       <= SAMPLE_LOAD;
                        r_sample_en <= 1'b1;
                        r_busy      <= 1'b1;
                        r_dac_code  <= '0;
                    end
                end

                SAMPLE: begin
                    if (bus.abort) begin
                        r_state     <= IDLE;
                        r_sample_en <= 1'b0;
                        r_busy      <= 1'b0;
                        r_dac_code  <= '0;
                    end else if (r_cnt == '0) begin
                        r_state     <= CONVERT;
                        r_sample_en <= 1'b0;
                        r_dac_code  <= MSB_CODE;
                        r_bit_idx   <= MSB_IDX;
                        r_cnt       <= BIT_LOAD;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end

                CONVERT: begin
                    // The cycle carrying the done pulse is still spent in
                    // CONVERT, so a start arriving alongside done is dropped.
                    if (bus.abort || r_done) begin
                        r_state     <= IDLE;
                        r_sample_en <= 1'b0;
                        r_busy      <= 1'b0;
                        r_dac_code  <= '0;
                    end else if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CW'(1);
                    end else if (r_bit_idx != '0) begin
                        r_dac_code <= w_next_trial;
                        r_bit_idx  <= r_bit_idx - IW'(1);
                        r_cnt      <= BIT_LOAD;
                    end else begin
                        r_result   <= w_keep_code;
                        r_done     <= 1'b1;
                        r_busy     <= 1'b0;
                        r_dac_code <= '0;
                    end
                end

                default: begin
                    r_state     <= IDLE;
                    r_sample_en <= 1'b0;
                    r_busy      <= 1'b0;
                    r_dac_code  <= '0;
                end
            endcase
        end
    end

    assign sample_en  = r_sample_en;
    assign dac_code   = r_dac_code;
    assign bus.busy   = r_busy;
    assign bus.done   = r_done;
    assign bus.result = r_result;
endmodule

// File: tb/tb_sar_adc_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sar_adc_ctrl
// Two controllers: A (BITS=8, SAMPLE=4, SETTLE=1) and B (BITS=12, SAMPLE=1,
// SETTLE=3). Each comparator is modelled as (vin >= dac_code), with optional
// tie-high / tie-low for A. Cycle c is the interval after clock edge c-1;
// start held during cycle 0 is taken at edge 0.
// -----------------------------------------------------------------------------
module tb_sar_adc_ctrl;
    localparam int BA = 8,  SA = 4, SETA = 1, TPA = SETA + 2;
    localparam int BB = 12, SB = 1, SETB = 3, TPB = SETB + 2;
    localparam int DONE_A = SA + BA * TPA + 1;
    localparam int DONE_B = SB + BB * TPB + 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [7:0]  vin_a = 8'h00;
    int          mode_a = 0;
    logic [11:0] vin_b = 12'h000;

    logic        comp_a, comp_b;
    logic        sample_en_a, sample_en_b;
    logic [7:0]  dac_a;
    logic [11:0] dac_b;

    sar_adc_ctrl_if #(.BITS(BA)) bus_a ();
    sar_adc_ctrl_if #(.BITS(BB)) bus_b ();

    assign comp_a = (mode_a == 1) ? 1'b1 : ((mode_a == 2) ? 1'b0 : (vin_a >= dac_a));
    assign comp_b = (vin_b >= dac_b);

    sar_adc_ctrl #(.BITS(BA), .SAMPLE_CYCLES(SA), .SETTLE_CYCLES(SETA)) dut_a (
        .clk(clk), .rst_n(rst_n), .comp_in(comp_a),
        .sample_en(sample_en_a), .dac_code(dac_a), .bus(bus_a)
    );

    sar_adc_ctrl #(.BITS(BB), .SAMPLE_CYCLES(SB), .SETTLE_CYCLES(SETB)) dut_b (
        .clk(clk), .rst_n(rst_n), .comp_in(comp_b),
        .sample_en(sample_en_b), .dac_code(dac_b), .bus(bus_b)
    );

    int total = 0;
    int bad = 0;
    logic [7:0] prev_res_a = 8'h00;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Ideal converter: the largest code whose DAC level does not exceed vin.
    function automatic int ref_sar(input int vin, input int bits);
        for (int c = (1 << bits) - 1; c >= 0; c--)
            if (c <= vin) return c;
        return 0;
    endfunction

    // Trial code on step k: bits already resolved from the final answer,
    // the bit under test set, everything below it clear.
    function automatic int trial_code(input int res, input int bits, input int k);
        int p;
        p = bits - 1 - k;
        return ((res >> (p + 1)) << (p + 1)) | (1 << p);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_a(input logic [7:0] vin, input int mode, input bit ab,
                         input logic [7:0] exp, input string name);
        int done_cyc = -1, done_cnt = 0, busy_err = 0, dac_err = 0, hold_err = 0;
        vin_a = vin;
        mode_a = mode;
        bus_a.start = 1'b1;
        bus_a.abort = ab;
        tick();
        bus_a.start = 1'b0;
        bus_a.abort = 1'b0;
        for (int c = 1; c <= DONE_A + 4; c++) begin
            if ((c < DONE_A) != bus_a.busy) busy_err++;
            if (bus_a.done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (c < DONE_A && bus_a.result != prev_res_a) hold_err++;
            if (c <= SA) begin
                if (!sample_en_a || dac_a != '0) dac_err++;
            end else if (c < DONE_A) begin
                if (sample_en_a || int'(dac_a) != trial_code(int'(exp), BA, (c - SA - 1) / TPA))
                    dac_err++;
            end else if (sample_en_a || dac_a != '0) begin
                dac_err++;
            end
            tick();
        end
        chk({name, " done_cycle"}, done_cyc, DONE_A);
        chk({name, " done_count"}, done_cnt, 1);
        chk({name, " busy_errs"}, busy_err, 0);
        chk({name, " dac_errs"}, dac_err, 0);
        chk({name, " result_hold_errs"}, hold_err, 0);
        chk({name, " result"}, int'(bus_a.result), int'(exp));
        prev_res_a = exp;
    endtask

    task automatic run_b(input logic [11:0] vin, input logic [11:0] exp, input string name);
        int done_cyc = -1, busy_err = 0, dac_err = 0;
        vin_b = vin;
        bus_b.start = 1'b1;
        tick();
        bus_b.start = 1'b0;
        for (int c = 1; c <= DONE_B + 4; c++) begin
            if ((c < DONE_B) != bus_b.busy) busy_err++;
            if (bus_b.done && done_cyc < 0) done_cyc = c;
            if (c > SB && c < DONE_B &&
                int'(dac_b) != trial_code(int'(exp), BB, (c - SB - 1) / TPB)) dac_err++;
            tick();
        end
        chk({name, " done_cycle"}, done_cyc, DONE_B);
        chk({name, " busy_errs"}, busy_err, 0);
        chk({name, " dac_errs"}, dac_err, 0);
        chk({name, " result"}, int'(bus_b.result), int'(exp));
    endtask

    // Extra starts during a conversion and on the done cycle are dropped;
    // a start on the cycle after done begins a second conversion.
    task automatic repulse_seq();
        int done_cnt = 0, first_done = -1, second_done = -1, busy_err = 0;
        bit exp_busy;
        vin_a = 8'h3C;
        mode_a = 0;
        for (int c = 0; c <= 2 * DONE_A + 4; c++) begin
            bus_a.start = (c == 0 || c == 3 || c == 10 || c == DONE_A || c == DONE_A + 1);
            if (c > 0) begin
                exp_busy = (c < DONE_A) || (c >= DONE_A + 2 && c <= 2 * DONE_A);
                if (exp_busy != bus_a.busy) busy_err++;
                if (bus_a.done) begin
                    done_cnt++;
                    if (first_done < 0) first_done = c;
                    else if (second_done < 0) second_done = c;
                end
            end
            tick();
        end
        bus_a.start = 1'b0;
        chk("repulse done_count", done_cnt, 2);
        chk("repulse first_done", first_done, DONE_A);
        chk("repulse second_done", second_done, 2 * DONE_A + 1);
        chk("repulse busy_errs", busy_err, 0);
        chk("repulse result", int'(bus_a.result), 'h3C);
        prev_res_a = 8'h3C;
    endtask

    task automatic abort_seq();
        int done_cnt = 0;
        vin_a = 8'hC3;
        mode_a = 0;
        for (int c = 0; c <= DONE_A + 4; c++) begin
            bus_a.start = (c == 0);
            bus_a.abort = (c == 12);
            if (c > 0 && bus_a.done) done_cnt++;
            if (c == 12) chk("abort busy_before", int'(bus_a.busy), 1);
            if (c == 13) begin
                chk("abort busy_after", int'(bus_a.busy), 0);
                chk("abort dac_after", int'(dac_a), 0);
                chk("abort sample_en_after", int'(sample_en_a), 0);
            end
            tick();
        end
        bus_a.start = 1'b0;
        chk("abort done_count", done_cnt, 0);
        chk("abort result_kept", int'(bus_a.result), 'h5A);
        bus_a.abort = 1'b1;
        repeat (3) tick();
        bus_a.abort = 1'b0;
        chk("abort_idle busy", int'(bus_a.busy), 0);
        chk("abort_idle result", int'(bus_a.result), 'h5A);
    endtask

    task automatic reset_seq();
        vin_a = 8'h77;
        mode_a = 0;
        bus_a.start = 1'b1;
        tick();
        bus_a.start = 1'b0;
        tick();
        chk("rst_mid sample_en_before", int'(sample_en_a), 1);
        #2;
        rst_n = 1'b0;
        #2;
        chk("rst_mid sample_en", int'(sample_en_a), 0);
        chk("rst_mid busy", int'(bus_a.busy), 0);
        chk("rst_mid result", int'(bus_a.result), 0);
        chk("rst_mid dac", int'(dac_a), 0);
        tick();
        rst_n = 1'b1;
        tick();
        prev_res_a = 8'h00;
    endtask

    typedef struct {
        logic [7:0] vin;
        int         mode;
        bit         ab;
        logic [7:0] exp;
    } vec_t;

    initial begin
        vec_t vecs[$];
        vecs.push_back('{8'hA5, 0, 1'b0, 8'hA5});
        vecs.push_back('{8'h00, 1, 1'b0, 8'hFF});
        vecs.push_back('{8'h33, 2, 1'b0, 8'h00});
        vecs.push_back('{8'h5A, 0, 1'b1, 8'h5A});
        vecs.push_back('{8'h00, 0, 1'b0, 8'h00});
        vecs.push_back('{8'hFF, 0, 1'b0, 8'hFF});
        vecs.push_back('{8'h01, 0, 1'b0, 8'h01});
        vecs.push_back('{8'h80, 0, 1'b0, 8'h80});

        bus_a.start = 1'b0;
        bus_a.abort = 1'b0;
        bus_b.start = 1'b0;
        bus_b.abort = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("reset sample_en", int'(sample_en_a), 0);
        chk("reset dac", int'(dac_a), 0);
        chk("reset busy", int'(bus_a.busy), 0);
        chk("reset done", int'(bus_a.done), 0);
        chk("reset result", int'(bus_a.result), 0);
        chk("reset b_result", int'(bus_b.result), 0);
        rst_n = 1'b1;
        repeat (2) tick();

        foreach (vecs[i])
            run_a(vecs[i].vin, vecs[i].mode, vecs[i].ab, vecs[i].exp, $sformatf("vec%0d", i));

        run_a(8'h5A, 0, 1'b0, 8'h5A, "pre_abort");
        abort_seq();
        repulse_seq();
        reset_seq();
        run_a(8'h96, 0, 1'b0, 8'h96, "post_reset");

        for (int i = 0; i < 8; i++) begin
            logic [7:0] v;
            v = 8'($urandom_range(0, 255));
            repeat ($urandom_range(0, 3)) tick();
            run_a(v, 0, 1'b0, 8'(ref_sar(int'(v), BA)), $sformatf("rand%0d", i));
        end

        run_b(12'h800, 12'(ref_sar('h800, BB)), "b_800");
        begin
            logic [11:0] vb;
            vb = 12'($urandom_range(0, 4095));
            run_b(vb, 12'(ref_sar(int'(vb), BB)), "b_rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end
endmodule
